ddr2_ring_mover: RTL and testbench
==================================

# ddr2_ring_mover

Parametrised DDR2 data mover that turns a window of external DDR2 into one large ring-buffer FIFO between the host pipe FIFOs and a MIG user port (P0). It is the successor of the fixed-burst `ddr2_test` block. It adds configurable data width, burst length and window size, automatic address wrap-around, occupancy tracking so reads never overtake writes, and fair read/write arbitration. It sits between the pipe-in/pipe-out FIFOs and the `memc3` user port, all in the `c3_clk0` domain.

## Interface
Parameters:
- `DATA_W`, 32: user-port data width; must match the MIG port size.
- `MASK_W`, `DATA_W/8`: byte-mask width; also the byte stride per word.
- `BURST_LEN`, 32: words per MIG command, 1..64.
- `WIN_WORDS`, 8192: ring window in words; must be a multiple of `BURST_LEN`.
- `ADDR_W`, 30: MIG byte-address width.
- `CNT_W`, 10: width of the pipe-FIFO data counts.
- `OB_LIMIT`, 1023-20-32: a read burst may start only while `ob_count` is at or below this value.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: the `c3_clk0` clock.
  - `reset` in 1: synchronous, active-high.
- Control and status:
  - `calib_done` in 1: MIG calibration complete.
  - `writes_en` in 1: permits write bursts.
  - `reads_en` in 1: permits read bursts.
  - `base_addr` in ADDR_W: window base byte address; must be aligned to `BURST_LEN*MASK_W`.
  - `level` out clog2(WIN_WORDS+1): number of words held in DDR.
  - `busy` out 1: high whenever the state is not IDLE.
- Pipe-in FIFO:
  - `ib_re` out 1: read strobe.
  - `ib_data` in DATA_W: read data.
  - `ib_count` in CNT_W: read-side data count.
  - `ib_valid` in 1: `ib_data` is valid; one cycle after `ib_re`.
- Pipe-out FIFO:
  - `ob_we` out 1: write strobe.
  - `ob_data` out DATA_W: write data.
  - `ob_count` in CNT_W: write-side data count.
- MIG P0 command port:
  - `p0_cmd_en` out 1: command strobe.
  - `p0_cmd_instr` out 3: command instruction.
  - `p0_cmd_bl` out 6: burst length minus one.
  - `p0_cmd_byte_addr` out ADDR_W: command byte address.
  - `p0_cmd_full` in 1: command FIFO full.
- MIG P0 write port:
  - `p0_wr_en` out 1: write strobe.
  - `p0_wr_data` out DATA_W: write data.
  - `p0_wr_mask` out MASK_W: write byte mask; tied to all zeros.
  - `p0_wr_full` in 1: write FIFO full.
- MIG P0 read port:
  - `p0_rd_en` out 1: read strobe.
  - `p0_rd_data` in DATA_W: read data.
  - `p0_rd_empty` in 1: read FIFO empty.

## Operation
- FSM states: IDLE, WR_DATA, WR_CMD, RD_CMD, RD_DATA.
- Write is eligible when all hold: `calib_done`, `writes_en`, `ib_count >= BURST_LEN`, and `level <= WIN_WORDS-BURST_LEN`.
- Read is eligible when all hold: `calib_done`, `reads_en`, `level >= BURST_LEN`, and `ob_count <= OB_LIMIT`.
- IDLE arbitration:
  - Only one direction eligible: it is granted.
  - Both eligible: grant the direction not served last (round-robin). `last_wr` resets to 0, so write wins first.
- WR_DATA:
  - `ib_re` is asserted while fewer than `BURST_LEN` words have been requested and `p0_wr_full` is low.
  - Each `ib_valid` word goes to `p0_wr_en`/`p0_wr_data` if `p0_wr_full` is low; otherwise it is held in a one-entry skid register, which drains first.
  - Move to WR_CMD once `BURST_LEN` words have been pushed.
- WR_CMD: when `p0_cmd_full` is low, pulse `p0_cmd_en` for one cycle with:
  - `p0_cmd_instr` = 3'b000.
  - `p0_cmd_bl` = `BURST_LEN-1`.
  - `p0_cmd_byte_addr` = `base_addr + wr_ptr*MASK_W`.
  - Same cycle: `wr_ptr += BURST_LEN`, wrapping to 0 when it reaches `WIN_WORDS`; `level += BURST_LEN`; then go to IDLE.
- RD_CMD: same as WR_CMD but with instr 3'b001 and `rd_ptr`; then go to RD_DATA. `rd_ptr` wraps the same way.
- RD_DATA:
  - `p0_rd_en = ob_we = !p0_rd_empty`, combinationally.
  - `ob_data = p0_rd_data` (the MIG read port is first-word-fall-through).
  - After `BURST_LEN` words: `level -= BURST_LEN`, go to IDLE.
- Dropping `writes_en`/`reads_en` mid-burst does not abort; the current burst completes.
- `calib_done` low holds the FSM in IDLE.
- `base_addr` is sampled only at command issue; it must not change while `level != 0`.

## Timing
- Reset:
  - All outputs are 0; `p0_wr_mask` = 0.
  - `wr_ptr`, `rd_ptr`, `level`, `last_wr` and the skid register are cleared; FSM goes to IDLE.
  - Reset mid-burst aborts immediately. MIG state is not recovered; a MIG reset is required.
- Latency:
  - First `ib_re` occurs 1 cycle after the IDLE grant; first `p0_wr_en` 2 cycles after the grant.
  - `p0_cmd_en` comes no earlier than 1 cycle after the last `p0_wr_en`.
  - A read command is issued 1 cycle after its grant, given `p0_cmd_full` is low.
- Each burst returns through IDLE for one cycle, so the minimum gap between bursts is 1 cycle.
- `level` updates on the `p0_cmd_en` cycle for writes and on the last `ob_we` for reads. It never exceeds `WIN_WORDS` and never underflows.
- Simultaneous eligibility is resolved in one cycle; no combinational path from `ib_count`/`ob_count` to strobes.

## Structure
- Package `ddr2_pkg`:
  - MIG instruction constants: `MIG_WR`=3'b000, `MIG_RD`=3'b001.
  - FSM state enum.
  - `clog2` helper.
- Sub-module `wr_skid_reg`: a one-entry skid buffer on the `p0_wr` path. It has valid/ready semantics and is reset by `reset`.

## Test plan
- Reset test: assert `reset` with random inputs → all outputs 0, `level`=0, `busy`=0.
- Single write burst: `BURST_LEN`=32, `base_addr`=0x1000, 32 words 0..31 in ib, `writes_en` → expect:
  - exactly 32 `p0_wr_en` carrying 0..31 in order;
  - one `p0_cmd_en` with instr 000, bl 31, addr 0x1000;
  - `level`=32 afterwards.
- Read back: then `reads_en` → expect one command with instr 001, addr 0x1000, then 32 `ob_we` carrying 0..31, then `level`=0.
- Wrap-around: `WIN_WORDS`=64, alternating write/read bursts → expect write addresses 0x1000, 0x1080, 0x1000 and read addresses in the same sequence; data is intact.
- Arbitration: both directions continuously eligible → grants alternate W,R,W,R; with `level`=64=`WIN_WORDS`, writes are blocked even though `ib_count`=100.
- Backpressure: `p0_wr_full` high for 5 cycles mid-burst, and `p0_cmd_full` high for 3 cycles → no lost or duplicated words, and exactly one `p0_cmd_en` after `p0_cmd_full` falls.

Source files
------------

// File: rtl/ddr2_pkg.sv
// Shared constants and types for the DDR2 ring-buffer mover: MIG command
// encodings, the mover FSM state set and a constant-foldable log2 helper.
package ddr2_pkg;

    localparam logic [2:0] MIG_WR = 3'b000;
    localparam logic [2:0] MIG_RD = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_CMD  = 3'd2,
        ST_RD_CMD  = 3'd3,
        ST_RD_DATA = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/wr_skid_reg.sv
// One-entry skid buffer on the MIG write-data path. A stored word always
// leaves before a newly arriving one, so word order is preserved.
module wr_skid_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    logic              full;
    logic [DATA_W-1:0] hold;

    assign in_ready  = !full;
    assign out_valid = full || in_valid;
    assign out_data  = full ? hold : in_data;

    // Capture a word the sink refused; release it once the sink is ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            hold <= '0;
        end else if (full) begin
            if (out_ready) begin
                if (in_valid) begin
                    hold <= in_data;
                end else begin
                    full <= 1'b0;
                end
            end
        end else if (in_valid && !out_ready) begin
            full <= 1'b1;
            hold <= in_data;
        end
    end

endmodule

// File: rtl/ddr2_ring_mover.sv
// DDR2 window used as a ring-buffer FIFO between the pipe-in/pipe-out FIFOs
// and MIG port P0, with occupancy tracking and round-robin arbitration.
module ddr2_ring_mover
    import ddr2_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MASK_W    = DATA_W / 8,
    parameter int BURST_LEN = 32,
    parameter int WIN_WORDS = 8192,
    parameter int ADDR_W    = 30,
    parameter int CNT_W     = 10,
    parameter int OB_LIMIT  = 1023 - 20 - 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              calib_done,
    input  logic                              writes_en,
    input  logic                              reads_en,
    input  logic [ADDR_W-1:0]                 base_addr,
    output logic [clog2(WIN_WORDS + 1)-1:0]   level,
    output logic                              busy,
    output logic                              ib_re,
    input  logic [DATA_W-1:0]                 ib_data,
    input  logic [CNT_W-1:0]                  ib_count,
    input  logic                              ib_valid,
    output logic                              ob_we,
    output logic [DATA_W-1:0]                 ob_data,
    input  logic [CNT_W-1:0]                  ob_count,
    output logic                              p0_cmd_en,
    output logic [2:0]                        p0_cmd_instr,
    output logic [5:0]                        p0_cmd_bl,
    output logic [ADDR_W-1:0]                 p0_cmd_byte_addr,
    input  logic                              p0_cmd_full,
    output logic                              p0_wr_en,
    output logic [DATA_W-1:0]                 p0_wr_data,
    output logic [MASK_W-1:0]                 p0_wr_mask,
    input  logic                              p0_wr_full,
    output logic                              p0_rd_en,
    input  logic [DATA_W-1:0]                 p0_rd_data,
    input  logic                              p0_rd_empty
);

    localparam int LVL_W  = clog2(WIN_WORDS + 1);
    localparam int BCNT_W = clog2(BURST_LEN + 1);
    localparam logic [LVL_W-1:0]  BL_L    = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]  WIN_L   = LVL_W'(WIN_WORDS);
    localparam logic [BCNT_W-1:0] BL_C    = BCNT_W'(BURST_LEN);
    localparam logic [BCNT_W-1:0] BL_LAST = BCNT_W'(BURST_LEN - 1);

    state_t            state;
    logic [LVL_W-1:0]  wr_ptr;
    logic [LVL_W-1:0]  rd_ptr;
    logic              last_wr;
    logic [BCNT_W-1:0] req_cnt;
    logic [BCNT_W-1:0] push_cnt;
    logic [BCNT_W-1:0] rd_cnt;

    logic              wr_elig;
    logic              rd_elig;
    logic              wr_path_ready;
    logic              skid_in_ready;
    logic              skid_out_valid;
    logic [DATA_W-1:0] skid_out_data;

    function automatic logic [LVL_W-1:0] advance(input logic [LVL_W-1:0] ptr);
        if (ptr + BL_L >= WIN_L) begin
            return '0;
        end else begin
            return ptr + BL_L;
        end
    endfunction

    assign wr_elig = calib_done && writes_en
                     && (32'(ib_count) >= 32'(BURST_LEN))
                     && (level <= WIN_L - BL_L);
    assign rd_elig = calib_done && reads_en
                     && (level >= BL_L)
                     && (32'(ob_count) <= 32'(OB_LIMIT));

    // ib_re looks at the skid state so at most one word can be in flight
    // when the MIG write FIFO fills.
    assign wr_path_ready = (state == ST_WR_DATA) && !p0_wr_full;
    assign ib_re         = (state == ST_WR_DATA) && (req_cnt < BL_C)
                           && !p0_wr_full && skid_in_ready;
    assign p0_wr_en      = wr_path_ready && skid_out_valid;
    assign p0_wr_data    = p0_wr_en ? skid_out_data : '0;
    assign p0_wr_mask    = '0;

    assign p0_rd_en = (state == ST_RD_DATA) && !p0_rd_empty;
    assign ob_we    = p0_rd_en;
    assign ob_data  = p0_rd_en ? p0_rd_data : '0;
    assign busy     = (state != ST_IDLE);

    wr_skid_reg #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (ib_valid),
        .in_data   (ib_data),
        .in_ready  (skid_in_ready),
        .out_valid (skid_out_valid),
        .out_data  (skid_out_data),
        .out_ready (wr_path_ready)
    );

    // Command port decode; fields stay zero outside an issuing cycle.
    always_comb begin
        p0_cmd_en        = 1'b0;
        p0_cmd_instr     = 3'b000;
        p0_cmd_bl        = 6'd0;
        p0_cmd_byte_addr = '0;
        case (state)
            ST_WR_CMD: begin
                if (!p0_cmd_full) begin
                    p0_cmd_en        = 1'b1;
                    p0_cmd_instr     = MIG_WR;
                    p0_cmd_bl        = 6'(BURST_LEN - 1);
                    p0_cmd_byte_addr = base_addr + ADDR_W'(wr_ptr) * ADDR_W'(MASK_W);
                end else begin
                    p0_cmd_en = 1'b0;
                end
            end
            ST_RD_CMD: begin
                if (!p0_cmd_full) begin
                    p0_cmd_en        = 1'b1;
                    p0_cmd_instr     = MIG_RD;
                    p0_cmd_bl        = 6'(BURST_LEN - 1);
                    p0_cmd_byte_addr = base_addr + ADDR_W'(rd_ptr) * ADDR_W'(MASK_W);
                end else begin
                    p0_cmd_en = 1'b0;
                end
            end
            default: begin
                p0_cmd_en = 1'b0;
            end
        endcase
    end

    // Burst sequencer, ring pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            last_wr  <= 1'b0;
            req_cnt  <= '0;
            push_cnt <= '0;
            rd_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_cnt  <= '0;
                    push_cnt <= '0;
                    rd_cnt   <= '0;
                    if (wr_elig && (!rd_elig || !last_wr)) begin
                        state   <= ST_WR_DATA;
                        last_wr <= 1'b1;
                    end else if (rd_elig) begin
                        state   <= ST_RD_CMD;
                        last_wr <= 1'b0;
                    end
                end
                ST_WR_DATA: begin
                    if (ib_re) begin
                        req_cnt <= req_cnt + BCNT_W'(1);
                    end
                    if (p0_wr_en) begin
                        push_cnt <= push_cnt + BCNT_W'(1);
                        if (push_cnt == BL_LAST) begin
                            state <= ST_WR_CMD;
                        end
                    end
                end
                ST_WR_CMD: begin
                    if (!p0_cmd_full) begin
                        wr_ptr <= advance(wr_ptr);
                        level  <= level + BL_L;
                        state  <= ST_IDLE;
                    end
                end
                ST_RD_CMD: begin
                    if (!p0_cmd_full) begin
                        rd_ptr <= advance(rd_ptr);
                        state  <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (p0_rd_en) begin
                        rd_cnt <= rd_cnt + BCNT_W'(1);
                        if (rd_cnt == BL_LAST) begin
                            level <= level - BL_L;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_ring_mover.sv
// Directed bench for ddr2_ring_mover with a 64-word window: pipe-FIFO and MIG
// port models, a burst table and hand sequences for arbitration and stalls.
module tb_ddr2_ring_mover;

    localparam int BL = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        calib_done, writes_en, reads_en;
    logic [29:0] base_addr;
    logic [6:0]  level;
    logic        busy;
    logic        ib_re;
    logic [31:0] ib_data;
    logic [9:0]  ib_count;
    logic        ib_valid;
    logic        ob_we;
    logic [31:0] ob_data;
    logic [9:0]  ob_count;
    logic        p0_cmd_en;
    logic [2:0]  p0_cmd_instr;
    logic [5:0]  p0_cmd_bl;
    logic [29:0] p0_cmd_byte_addr;
    logic        p0_cmd_full;
    logic        p0_wr_en;
    logic [31:0] p0_wr_data;
    logic [3:0]  p0_wr_mask;
    logic        p0_wr_full;
    logic        p0_rd_en;
    logic [31:0] p0_rd_data;
    logic        p0_rd_empty;

    int n_checks = 0;
    int n_errors = 0;
    int wr_expect = 0;
    int rd_expect = 0;
    int burst_words = 0;
    int cmd_count = 0;

    logic [31:0] ib_seq;
    logic [31:0] mem [0:63];
    logic [31:0] wbuf [$];
    logic [31:0] rdq [$];

    ddr2_ring_mover #(
        .DATA_W(32), .MASK_W(4), .BURST_LEN(BL), .WIN_WORDS(64),
        .ADDR_W(30), .CNT_W(10), .OB_LIMIT(1023 - 20 - 32)
    ) dut (
        .clk(clk), .reset(reset), .calib_done(calib_done),
        .writes_en(writes_en), .reads_en(reads_en), .base_addr(base_addr),
        .level(level), .busy(busy),
        .ib_re(ib_re), .ib_data(ib_data), .ib_count(ib_count), .ib_valid(ib_valid),
        .ob_we(ob_we), .ob_data(ob_data), .ob_count(ob_count),
        .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl),
        .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_full(p0_cmd_full),
        .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask),
        .p0_wr_full(p0_wr_full),
        .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data), .p0_rd_empty(p0_rd_empty)
    );

    always #5 clk = ~clk;

    function automatic int widx(input logic [29:0] addr, input int i);
        return int'((addr - 30'h1000) >> 2) + i;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pipe-in FIFO (one-cycle read latency) and MIG P0 model with FWFT read port.
    always @(posedge clk) begin
        if (reset) begin
            ib_valid    <= 1'b0;
            ib_data     <= 32'd0;
            ib_seq      <= 32'd0;
            p0_rd_empty <= 1'b1;
            p0_rd_data  <= 32'd0;
            wbuf.delete();
            rdq.delete();
        end else begin
            ib_valid <= ib_re;
            if (ib_re) begin
                ib_data <= ib_seq;
                ib_seq  <= ib_seq + 32'd1;
            end
            if (p0_wr_en) wbuf.push_back(p0_wr_data);
            if (p0_rd_en && rdq.size() > 0) void'(rdq.pop_front());
            if (p0_cmd_en && p0_cmd_instr == 3'b000) begin
                for (int i = 0; i < BL; i++)
                    if (wbuf.size() > 0) mem[widx(p0_cmd_byte_addr, i)] <= wbuf.pop_front();
            end else if (p0_cmd_en && p0_cmd_instr == 3'b001) begin
                for (int i = 0; i < BL; i++) rdq.push_back(mem[widx(p0_cmd_byte_addr, i)]);
            end
            p0_rd_empty <= (rdq.size() == 0);
            p0_rd_data  <= (rdq.size() > 0) ? rdq[0] : 32'd0;
        end
    end

    // Mid-cycle monitor: data order on both sides and words per write command.
    initial forever begin
        @(negedge clk);
        if (p0_wr_en) begin
            check("wr_data", 64'(p0_wr_data), 64'(wr_expect));
            check("wr_mask", 64'(p0_wr_mask), 64'd0);
            wr_expect++;
            burst_words++;
        end
        if (ob_we) begin
            check("ob_data", 64'(ob_data), 64'(rd_expect));
            rd_expect++;
        end
        if (p0_cmd_en) begin
            cmd_count++;
            if (p0_cmd_instr == 3'b000) begin
                check("words_per_wr_cmd", 64'(burst_words), 64'(BL));
                burst_words = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(output logic [2:0] instr, output logic [29:0] addr,
                            output logic [5:0] bl);
        bit ok = 1'b0;
        instr = 3'b111;
        addr  = '0;
        bl    = '0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (p0_cmd_en) begin
                instr = p0_cmd_instr;
                addr  = p0_cmd_byte_addr;
                bl    = p0_cmd_bl;
                ok    = 1'b1;
                break;
            end
        end
        check("cmd_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 64'(ok), 64'd1);
    endtask

    typedef struct {
        bit          we;
        bit          re;
        logic [2:0]  instr;
        logic [29:0] addr;
        logic [6:0]  lvl;
    } step_t;

    step_t       steps [8];
    logic [2:0]  c_instr;
    logic [29:0] c_addr;
    logic [5:0]  c_bl;
    logic [2:0]  arb_exp [4];
    bit          stayed_idle;
    int          cc;
    int          start_w;

    initial begin
        steps[0] = '{1'b1, 1'b0, 3'b000, 30'h1000, 7'd32};
        steps[1] = '{1'b0, 1'b1, 3'b001, 30'h1000, 7'd0};
        steps[2] = '{1'b1, 1'b0, 3'b000, 30'h1080, 7'd32};
        steps[3] = '{1'b0, 1'b1, 3'b001, 30'h1080, 7'd0};
        steps[4] = '{1'b1, 1'b0, 3'b000, 30'h1000, 7'd32};
        steps[5] = '{1'b0, 1'b1, 3'b001, 30'h1000, 7'd0};
        steps[6] = '{1'b1, 1'b0, 3'b000, 30'h1080, 7'd32};
        steps[7] = '{1'b1, 1'b0, 3'b000, 30'h1000, 7'd64};

        // Reset with random control inputs.
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            calib_done  = 1'($urandom);
            writes_en   = 1'($urandom);
            reads_en    = 1'($urandom);
            base_addr   = 30'($urandom);
            ib_count    = 10'($urandom);
            ob_count    = 10'($urandom);
            p0_cmd_full = 1'($urandom);
            p0_wr_full  = 1'($urandom);
            tick();
        end
        check("reset_outputs",
              64'({ib_re, ob_we, ob_data, p0_cmd_en, p0_cmd_instr, p0_cmd_bl}), 64'd0);
        check("reset_p0_outputs",
              64'({p0_cmd_byte_addr, p0_wr_en, p0_wr_data, p0_wr_mask, p0_rd_en}), 64'd0);
        check("reset_level", 64'(level), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        calib_done  = 1'b1;
        writes_en   = 1'b0;
        reads_en    = 1'b0;
        base_addr   = 30'h1000;
        ib_count    = 10'd100;
        ob_count    = 10'd0;
        p0_cmd_full = 1'b0;
        p0_wr_full  = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Alternating bursts around the 64-word ring, then fill it.
        for (int i = 0; i < 8; i++) begin
            writes_en = steps[i].we;
            reads_en  = steps[i].re;
            if (i == 0) begin
                tick();
                check("first_ib_re_latency", 64'(ib_re), 64'd1);
                tick();
                check("first_wr_en_latency", 64'(p0_wr_en), 64'd1);
            end
            wait_cmd(c_instr, c_addr, c_bl);
            writes_en = 1'b0;
            reads_en  = 1'b0;
            check($sformatf("step%0d_instr", i), 64'(c_instr), 64'(steps[i].instr));
            check($sformatf("step%0d_addr", i), 64'(c_addr), 64'(steps[i].addr));
            check($sformatf("step%0d_bl", i), 64'(c_bl), 64'd31);
            wait_idle();
            check($sformatf("step%0d_level", i), 64'(level), 64'(steps[i].lvl));
        end

        // Full window: writes stay blocked despite a deep pipe-in FIFO.
        cc = cmd_count;
        stayed_idle = 1'b1;
        writes_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (busy) stayed_idle = 1'b0;
        end
        writes_en = 1'b0;
        check("full_blocks_write", 64'({stayed_idle, level}), 64'({1'b1, 7'd64}));
        check("full_no_cmd", 64'(cmd_count), 64'(cc));

        // Both eligible from a full window after a write: R,W,R,W.
        arb_exp = '{3'b001, 3'b000, 3'b001, 3'b000};
        writes_en = 1'b1;
        reads_en  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_cmd(c_instr, c_addr, c_bl);
            check($sformatf("arbA_grant%0d", k), 64'(c_instr), 64'(arb_exp[k]));
        end
        writes_en = 1'b0;
        reads_en  = 1'b0;
        wait_idle();
        check("arbA_level", 64'(level), 64'd64);

        for (int k = 0; k < 2; k++) begin
            reads_en = 1'b1;
            wait_cmd(c_instr, c_addr, c_bl);
            reads_en = 1'b0;
            wait_idle();
        end
        check("drain_level", 64'(level), 64'd0);

        // Both eligible from empty: W,R,W,R.
        arb_exp = '{3'b000, 3'b001, 3'b000, 3'b001};
        writes_en = 1'b1;
        reads_en  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_cmd(c_instr, c_addr, c_bl);
            check($sformatf("arbB_grant%0d", k), 64'(c_instr), 64'(arb_exp[k]));
        end
        writes_en = 1'b0;
        reads_en  = 1'b0;
        wait_idle();
        check("arbB_level", 64'(level), 64'd0);

        // Backpressure: write FIFO full 5 cycles mid-burst, then command FIFO full 3 cycles.
        start_w = wr_expect;
        writes_en = 1'b1;
        for (int c = 0; c < 200 && wr_expect < start_w + 10; c++) tick();
        writes_en  = 1'b0;
        p0_wr_full = 1'b1;
        repeat (5) tick();
        p0_wr_full  = 1'b0;
        p0_cmd_full = 1'b1;
        cc = cmd_count;
        for (int c = 0; c < 200 && wr_expect < start_w + BL; c++) tick();
        repeat (3) tick();
        check("bp_words_pushed", 64'(wr_expect - start_w), 64'(BL));
        check("bp_cmd_held", 64'({busy, p0_cmd_en}), 64'({1'b1, 1'b0}));
        check("bp_no_cmd_yet", 64'(cmd_count), 64'(cc));
        p0_cmd_full = 1'b0;
        #1;
        check("bp_cmd_after_release", 64'(p0_cmd_en), 64'd1);
        check("bp_cmd_addr", 64'(p0_cmd_byte_addr), 64'h1080);
        tick();
        tick();
        check("bp_single_cmd", 64'(cmd_count), 64'(cc + 1));
        check("bp_level", 64'(level), 64'd32);

        reads_en = 1'b1;
        wait_cmd(c_instr, c_addr, c_bl);
        reads_en = 1'b0;
        check("bp_read_addr", 64'({c_instr, c_addr}), 64'({3'b001, 30'h1080}));
        wait_idle();
        check("final_level", 64'(level), 64'd0);
        check("words_written", 64'(wr_expect), 64'(10 * BL));
        check("words_read", 64'(rd_expect), 64'(10 * BL));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
